// File: rtl/i2s_rx_pkg.sv
// i2s_rx_pkg: shared audio constants, I2S channel-select convention and receiver state encoding.
package i2s_rx_pkg;

    localparam int DEF_AUDIO_DW = 16;
    localparam int DEF_TIMEOUT  = 1024;

    localparam logic LR_LEFT  = 1'b0;
    localparam logic LR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } rx_state_t;

endpackage

// File: rtl/i2s_rx_sync.sv
// i2s_rx_sync: brings sclk/lrclk/sdata into clk_sys through 2-FF synchronisers and flags sclk rising edges.
// The rise strobe is registered, with lrclk_s/sdata_s delayed to stay aligned with it.
module i2s_rx_sync (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic sclk,
    input  logic lrclk,
    input  logic sdata,
    output logic lrclk_s,
    output logic sdata_s,
    output logic rise
);

    logic [1:0] sclk_ff;
    logic [1:0] lrclk_ff;
    logic [1:0] sdata_ff;
    logic       sclk_h;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sclk_ff  <= '0;
            lrclk_ff <= '0;
            sdata_ff <= '0;
            sclk_h   <= 1'b0;
            rise     <= 1'b0;
            lrclk_s  <= 1'b0;
            sdata_s  <= 1'b0;
        end else begin
            sclk_ff  <= {sclk_ff[0], sclk};
            lrclk_ff <= {lrclk_ff[0], lrclk};
            sdata_ff <= {sdata_ff[0], sdata};
            sclk_h   <= sclk_ff[1];
            rise     <= sclk_ff[1] & ~sclk_h;
            lrclk_s  <= lrclk_ff[1];
            sdata_s  <= sdata_ff[1];
        end
    end

endmodule

// File: rtl/i2s_rx.sv
// i2s_rx: standard-I2S receiver; frames sclk/lrclk/sdata into left/right PCM words
// with a one-cycle sample_valid per frame and a lock indicator with sclk-loss timeout.
module i2s_rx
    import i2s_rx_pkg::*;
#(
    parameter int AUDIO_DW = DEF_AUDIO_DW,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic                sclk,
    input  logic                lrclk,
    input  logic                sdata,
    output logic [AUDIO_DW-1:0] left_chan,
    output logic [AUDIO_DW-1:0] right_chan,
    output logic                sample_valid,
    output logic                locked
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic lrclk_s, sdata_s, rise;

    rx_state_t           state, state_nx;
    logic                lr_prev, lr_prev_nx;
    logic [7:0]          bcnt, bcnt_nx;
    logic [AUDIO_DW-1:0] sh, sh_nx, word, bit_pos;
    logic [AUDIO_DW-1:0] left_pend, left_pend_nx;
    logic [AUDIO_DW-1:0] left_nx, right_nx;
    logic                have_left, have_left_nx;
    logic                valid_nx;
    logic [TW-1:0]       tcnt, tcnt_nx;
    logic                change, left_done, right_done, timeout;

    i2s_rx_sync u_sync (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .sclk    (sclk),
        .lrclk   (lrclk),
        .sdata   (sdata),
        .lrclk_s (lrclk_s),
        .sdata_s (sdata_s),
        .rise    (rise)
    );

    assign locked = (state == LOCKED);

    always_comb begin
        change     = rise && (lrclk_s != lr_prev);
        left_done  = change && (lr_prev == LR_LEFT);
        right_done = change && (lr_prev != LR_LEFT);
        timeout    = !rise && (tcnt >= TW'(TIMEOUT - 1));
        // bits land at their final left-justified position, so short words are zero-filled for free
        bit_pos    = AUDIO_DW'(1) << (AUDIO_DW - 1 - int'(bcnt));
        word       = (int'(bcnt) < AUDIO_DW && sdata_s) ? (sh | bit_pos) : sh;
        state_nx     = state;
        lr_prev_nx   = rise ? lrclk_s : lr_prev;
        bcnt_nx      = bcnt;
        sh_nx        = sh;
        left_pend_nx = left_pend;
        have_left_nx = have_left;
        left_nx      = left_chan;
        right_nx     = right_chan;
        valid_nx     = 1'b0;
        tcnt_nx      = rise ? '0 : (tcnt == TW'(TIMEOUT) ? tcnt : tcnt + TW'(1));
        if (rise) begin
            bcnt_nx = change ? 8'd0 : (bcnt == 8'hFF ? bcnt : bcnt + 8'd1);
            sh_nx   = change ? '0 : word;
        end
        case (state)
            HUNT: begin
                if (change) begin
                    state_nx     = SYNC;
                    have_left_nx = 1'b0;
                end
            end
            SYNC, LOCKED: begin
                if (left_done) begin
                    left_pend_nx = word;
                    have_left_nx = 1'b1;
                end
                if (right_done && have_left) begin
                    left_nx      = left_pend;
                    right_nx     = word;
                    valid_nx     = 1'b1;
                    state_nx     = LOCKED;
                    have_left_nx = 1'b0;
                end
            end
            default: state_nx = HUNT;
        endcase
        if (timeout) begin
            state_nx     = HUNT;
            bcnt_nx      = 8'd0;
            sh_nx        = '0;
            have_left_nx = 1'b0;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state        <= HUNT;
            lr_prev      <= 1'b0;
            bcnt         <= 8'd0;
            sh           <= '0;
            left_pend    <= '0;
            have_left    <= 1'b0;
            tcnt         <= '0;
            left_chan    <= '0;
            right_chan   <= '0;
            sample_valid <= 1'b0;
        end else begin
            state        <= state_nx;
            lr_prev      <= lr_prev_nx;
            bcnt         <= bcnt_nx;
            sh           <= sh_nx;
            left_pend    <= left_pend_nx;
            have_left    <= have_left_nx;
            tcnt         <= tcnt_nx;
            left_chan    <= left_nx;
            right_chan   <= right_nx;
            sample_valid <= valid_nx;
        end
    end

endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- Standard-I2S receiver. Recovers stereo PCM from an external master's sclk/lrclk/sdata into the clk_sys domain.
- Used on audio-input paths, e.g. external ADC/codec capture or loopback of the system's own I2S output.
- Emits one left/right sample pair per frame with a one-cycle valid strobe, plus a lock indicator.

Parameters:
- AUDIO_DW, 16: output sample width; bits captured MSB-first per channel.
- TIMEOUT, 1024: clk_sys cycles without an sclk rising edge before lock is dropped.

Ports:
- clk_sys  in  1  system clock; all logic in this domain.
- reset_n  in  1  asynchronous, active-low reset.
- sclk  in  1  external bit clock (asynchronous to clk_sys).
- lrclk  in  1  external word select; 0 = left, 1 = right.
- sdata  in  1  external serial data.
- left_chan  out  AUDIO_DW  last complete left sample.
- right_chan  out  AUDIO_DW  last complete right sample.
- sample_valid  out  1  one-cycle pulse when left_chan and right_chan update.
- locked  out  1  receiver synchronised to the frame structure.

Behaviour:
Reset and input conditioning:
- Reset (reset_n=0, async): left_chan=0, right_chan=0, sample_valid=0, locked=0, state=HUNT, counters and shifters cleared, sync flops set to 0.
- sclk, lrclk and sdata each pass through a 2-FF synchroniser plus one history flop.
- rise = sync_sclk & ~hist_sclk.
- All capture happens on cycles where rise=1, using the synchronised lrclk/sdata of that same cycle.
- Input requirement: sclk high and low phases each ≥ 3 clk_sys periods; violations are undefined and not detected.

Bit framing (standard I2S, one-bit delay):
- At a rise where lrclk differs from the lrclk value latched at the previous rise, that rise's sdata bit is the LSB (last bit) of the previous channel's word.
- The next rise carries the MSB of the new channel.
- A half-frame comprises the rises from the one after a change up to and including the next change rise.
- Bit counter bcnt is 8 bits and saturates at 255.
- Shift register sh (AUDIO_DW bits) accepts sdata only while bcnt < AUDIO_DW. Extra bits beyond AUDIO_DW are ignored, i.e. the word is truncated to its MSBs.
- Word completion at the change rise:
  - word = sh (including this rise's bit if bcnt < AUDIO_DW), left-justified.
  - If bcnt+1 < AUDIO_DW, the low bits are zero-filled.
  - Then bcnt and sh are cleared.

State machine:
- HUNT: wait for the first lrclk change rise; the partial half-frame is discarded. Go to SYNC.
- SYNC: complete the left word (lrclk change 0→1), then the right word (change 1→0). On completing the right word after a left word, go to LOCKED and set locked=1.
  - A right completion without a preceding left completion stays in SYNC.
- LOCKED: on each right-word completion, pending left word → left_chan and the right word → right_chan simultaneously; sample_valid=1 for exactly one cycle on the next clk_sys edge.
- The first completed frame in SYNC also updates the outputs and pulses sample_valid, in the same cycle locked rises.

Timing and timeout:
- Latency: sample_valid asserts on the 4th clk_sys posedge after the pin-level sclk rise carrying the right-channel LSB (2 sync + 1 edge detect + 1 output register).
- Timeout counter: cleared on every rise, otherwise increments and saturates.
  - Reaching TIMEOUT from any state: go to HUNT, locked=0, bcnt/sh cleared.
  - left_chan/right_chan hold their last values; no sample_valid is issued.
- Simultaneous timeout expiry and rise: the rise wins and the counter is cleared.
- Reset mid-frame: immediate return to HUNT; the partial word is lost.

Decomposition:
- Shared audio package holds:
  - state encoding (HUNT/SYNC/LOCKED, 2-bit);
  - the I2S channel-select convention (LR_LEFT=0, LR_RIGHT=1);
  - the default AUDIO_DW and TIMEOUT constants.
- One sub-module, i2s_rx_sync: 3-input 2-FF synchroniser plus sclk rise detector, async active-low reset. Outputs lrclk_s, sdata_s, rise.

Test Plan:
- Lock-up: drive 64-fs master (32 bits/channel), sclk = clk_sys/8, left=16'h8001, right=16'h7FFE. Required:
  - locked rises after the first full frame following the first lrclk change;
  - then left_chan=8001, right_chan=7FFE with one sample_valid per frame.
- Short word: 12 bits/channel sending 12'hABC / 12'h123. Required: left_chan=16'hABC0, right_chan=16'h1230.
- Latency: measure pin sclk rise of right LSB to sample_valid. Required: exactly 4 clk_sys cycles; pulse width 1.
- Timeout: stop sclk with TIMEOUT=64. Required:
  - locked=0 at the 64th idle cycle; outputs hold; no sample_valid;
  - on restart, relock after one full frame.
- Reset mid-frame: assert reset_n=0 during the left word. Required:
  - all outputs 0 asynchronously;
  - after release, the first valid pair is the first full frame after an lrclk change.
- Back-to-back samples: 100 frames of a ramp (left=n, right=~n). Required: each sample_valid presents matching pairs with no drops or duplicates.
